perf_memsys_ctrl: RTL and testbench
===================================

Name: perf_memsys_ctrl

Overview:
- Owns the memory-side performance counters (mem_reads, mem_writes, mem_latency) that feed the memsys perf interface; derives them from the cluster memory request/response handshakes.
- Tracks outstanding reads so per-cycle latency accumulates correctly.
- Provides enable/clear control and a snapshot-and-dump sequencer that streams a coherent counter set to the CSR/perf readout path one word per handshake.

Parameters:
- PERF_CTR_BITS, 44, width of every perf counter and of dump_data.
- MAX_PENDING, 64, maximum outstanding memory reads; pending counter width PENDW = clog2(MAX_PENDING+1).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- mem_req_valid  in  1  memory request valid
- mem_req_ready  in  1  memory request ready
- mem_req_rw  in  1  1 = write, 0 = read
- mem_rsp_valid  in  1  memory response valid (read data return)
- mem_rsp_ready  in  1  memory response ready
- ctrl_enable  in  1  counting enable
- ctrl_clear  in  1  synchronous clear of counters
- dump_start  in  1  pulse: snapshot and begin dump
- dump_valid  out  1  dump word valid
- dump_ready  in  1  consumer accepts dump word
- dump_idx  out  2  0 = reads, 1 = writes, 2 = latency
- dump_data  out  PERF_CTR_BITS  snapshot word
- dump_done  out  1  one-cycle pulse after last word accepted
- busy  out  1  dump sequencer not IDLE
- pending_reads  out  PENDW  outstanding reads
- err_underflow  out  1  sticky: response fired with pending_reads == 0
- mem_reads  out  PERF_CTR_BITS  live read count
- mem_writes  out  PERF_CTR_BITS  live write count
- mem_latency  out  PERF_CTR_BITS  live sum over cycles of pending_reads

Behaviour:
- Reset (async, on assertion): all counters, pending_reads, snapshot regs, dump_idx = 0; dump_valid, dump_done, busy, err_underflow = 0; FSM = IDLE.
- Fire terms:
  - rd_fire = mem_req_valid & mem_req_ready & ~mem_req_rw
  - wr_fire = mem_req_valid & mem_req_ready & mem_req_rw
  - rsp_fire = mem_rsp_valid & mem_rsp_ready
- pending_reads:
  - +1 on rd_fire only; −1 on rsp_fire only; unchanged when both fire.
  - Tracked regardless of ctrl_enable and ctrl_clear.
  - rsp_fire alone at 0: no decrement, set err_underflow.
  - rd_fire alone at MAX_PENDING: hold value (simulation assertion fires).
- Counters (registered; visible the cycle after the event), updated only when ctrl_enable = 1:
  - mem_reads += rd_fire
  - mem_writes += wr_fire
  - mem_latency += current registered pending_reads
  - All wrap modulo 2^PERF_CTR_BITS.
- ctrl_clear = 1: next-state of all three counters is 0. Clear wins over same-cycle events, which are lost. pending_reads and err_underflow are unaffected.
- Dump FSM:
  - IDLE: dump_start → capture the live counter registers into the snapshot (values before this cycle's update), dump_idx = 0, go DUMP.
  - DUMP: dump_valid = 1; dump_data = snapshot[dump_idx]; data stays stable while ~dump_ready. On dump_valid & dump_ready: if dump_idx < 2, increment dump_idx; if dump_idx == 2, go DONE.
  - DONE: dump_done = 1 for exactly one cycle; go IDLE.
  - busy = (state != IDLE).
  - dump_start outside IDLE is ignored.
  - ctrl_clear during DUMP does not alter the snapshot.
- Latency from dump_start to first dump_valid: 1 cycle. Minimum full dump: 5 cycles including DONE.

Decomposition:
- Shared perf package holds PERF_CTR_BITS, the dump index encoding (DUMP_IDX_READS = 0, DUMP_IDX_WRITES = 1, DUMP_IDX_LATENCY = 2, DUMP_WORDS = 3) and the FSM state enum (IDLE, DUMP, DONE).
- One sub-module, perf_pending_tracker, holds the up/down pending counter with underflow/overflow handling. Counters and FSM stay in the top.

Test Plan:
- Reset then enable; issue 3 reads on consecutive cycles, return 3 responses 10 cycles later one per cycle → mem_reads = 3, pending peaks at 3 and returns to 0, mem_latency = 33, err_underflow = 0.
- Same-cycle rd_fire and rsp_fire with pending = 2 → pending stays 2, mem_reads +1, mem_latency +2 that cycle.
- ctrl_enable = 0 for 5 cycles with 4 writes and pending = 1 → counters hold, pending still tracked; ctrl_clear with a concurrent write → mem_writes = 0 next cycle.
- Counters preloaded near wrap (mem_reads = 2^44−1) with one read → mem_reads wraps to 0.
- dump_start with reads = 7, writes = 5, latency = 40; dump_ready low for 3 cycles on idx 1; traffic continues during the dump → words 7, 5, 40 in order with stable data while stalled, dump_done one cycle after idx 2 accepted, second dump_start while busy ignored.
- rsp_fire with pending = 0, then assert reset mid-DUMP → err_underflow set and sticky until reset; reset asynchronously returns the FSM to IDLE, dump_valid = 0, all counters = 0.

Source files
------------

// File: rtl/perf_memsys_pkg.sv
// Shared definitions for the memory-side perf counters: counter width,
// dump word encoding and the dump sequencer states.
package perf_memsys_pkg;

  localparam int PERF_CTR_BITS = 44;

  localparam logic [1:0] DUMP_IDX_READS   = 2'd0;
  localparam logic [1:0] DUMP_IDX_WRITES  = 2'd1;
  localparam logic [1:0] DUMP_IDX_LATENCY = 2'd2;
  localparam int         DUMP_WORDS       = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DUMP = 2'd1,
    DONE = 2'd2
  } dump_state_e;

endpackage

// File: rtl/perf_pending_tracker.sv
// Up/down counter of outstanding memory reads; saturates at MAX_PENDING and
// flags a response arriving with nothing outstanding.
module perf_pending_tracker #(
  parameter int MAX_PENDING = 64,
  parameter int PENDW       = $clog2(MAX_PENDING + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [PENDW-1:0] count,
  output logic             err_underflow
);

  localparam logic [PENDW-1:0] MAX_CNT = PENDW'(MAX_PENDING);

  logic [PENDW-1:0] count_q, count_d;
  logic             err_q, err_d;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can
    // leave it unassigned and infer a latch.
    count_d = count_q;
    err_d   = err_q;
    if (inc && !dec) begin
      if (count_q != MAX_CNT) count_d = count_q + PENDW'(1);
    end else if (dec && !inc) begin
      if (count_q == '0) err_d = 1'b1;
      else               count_d = count_q - PENDW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign count         = count_q;
  assign err_underflow = err_q;

  // More reads than the memory system can hold in flight is a protocol bug upstream.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(inc && !dec && count_q == MAX_CNT));

endmodule

// File: rtl/perf_memsys_ctrl.sv
// Memory-side perf counters (reads, writes, read latency) with enable/clear
// and a snapshot-and-dump sequencer streaming one word per handshake.
module perf_memsys_ctrl
  import perf_memsys_pkg::*;
#(
  parameter int PERF_CTR_BITS = perf_memsys_pkg::PERF_CTR_BITS,
  parameter int MAX_PENDING   = 64,
  parameter int PENDW         = $clog2(MAX_PENDING + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  input  logic                     mem_req_rw,
  input  logic                     mem_rsp_valid,
  input  logic                     mem_rsp_ready,
  input  logic                     ctrl_enable,
  input  logic                     ctrl_clear,
  input  logic                     dump_start,
  output logic                     dump_valid,
  input  logic                     dump_ready,
  output logic [1:0]               dump_idx,
  output logic [PERF_CTR_BITS-1:0] dump_data,
  output logic                     dump_done,
  output logic                     busy,
  output logic [PENDW-1:0]         pending_reads,
  output logic                     err_underflow,
  output logic [PERF_CTR_BITS-1:0] mem_reads,
  output logic [PERF_CTR_BITS-1:0] mem_writes,
  output logic [PERF_CTR_BITS-1:0] mem_latency
);

  logic rd_fire, wr_fire, rsp_fire;
  assign rd_fire  = mem_req_valid & mem_req_ready & ~mem_req_rw;
  assign wr_fire  = mem_req_valid & mem_req_ready &  mem_req_rw;
  assign rsp_fire = mem_rsp_valid & mem_rsp_ready;

  // Pending reads are tracked even while counting is disabled or cleared.
  perf_pending_tracker #(
    .MAX_PENDING (MAX_PENDING),
    .PENDW       (PENDW)
  ) u_pending (
    .clk           (clk),
    .rst           (reset),
    .inc           (rd_fire),
    .dec           (rsp_fire),
    .count         (pending_reads),
    .err_underflow (err_underflow)
  );

  logic [PERF_CTR_BITS-1:0] reads_q,   reads_d;
  logic [PERF_CTR_BITS-1:0] writes_q,  writes_d;
  logic [PERF_CTR_BITS-1:0] latency_q, latency_d;

  always_comb begin
    reads_d   = reads_q;
    writes_d  = writes_q;
    latency_d = latency_q;
    if (ctrl_clear) begin
      reads_d   = '0;
      writes_d  = '0;
      latency_d = '0;
    end else if (ctrl_enable) begin
      reads_d   = reads_q   + PERF_CTR_BITS'(rd_fire);
      writes_d  = writes_q  + PERF_CTR_BITS'(wr_fire);
      latency_d = latency_q + PERF_CTR_BITS'(pending_reads);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reads_q   <= '0;
      writes_q  <= '0;
      latency_q <= '0;
    end else begin
      reads_q   <= reads_d;
      writes_q  <= writes_d;
      latency_q <= latency_d;
    end
  end

  assign mem_reads   = reads_q;
  assign mem_writes  = writes_q;
  assign mem_latency = latency_q;

  dump_state_e              state_q;
  logic [1:0]               dump_idx_q;
  logic                     dump_valid_q, dump_done_q, busy_q;
  logic [PERF_CTR_BITS-1:0] snap_q [DUMP_WORDS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      dump_idx_q   <= DUMP_IDX_READS;
      dump_valid_q <= 1'b0;
      dump_done_q  <= 1'b0;
      busy_q       <= 1'b0;
      // NOTE: the snapshot array is reset because dump_data is visible from
      // reset onward; a memory feeding only internal logic would not need it.
      for (int i = 0; i < DUMP_WORDS; i++) snap_q[i] <= '0;
    end else begin
      dump_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (dump_start) begin
            // Registered values, i.e. the set as it stood before this cycle's events.
            snap_q[DUMP_IDX_READS]   <= reads_q;
            snap_q[DUMP_IDX_WRITES]  <= writes_q;
            snap_q[DUMP_IDX_LATENCY] <= latency_q;
            dump_idx_q   <= DUMP_IDX_READS;
            dump_valid_q <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= DUMP;
          end
        end
        DUMP: begin
          if (dump_ready) begin
            if (dump_idx_q == DUMP_IDX_LATENCY) begin
              dump_valid_q <= 1'b0;
              dump_done_q  <= 1'b1;
              state_q      <= DONE;
            end else begin
              dump_idx_q <= dump_idx_q + 2'd1;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          dump_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    dump_data = '0;
    case (dump_idx_q)
      DUMP_IDX_READS:   dump_data = snap_q[DUMP_IDX_READS];
      DUMP_IDX_WRITES:  dump_data = snap_q[DUMP_IDX_WRITES];
      DUMP_IDX_LATENCY: dump_data = snap_q[DUMP_IDX_LATENCY];
      default:          dump_data = '0;
    endcase
  end

  assign dump_valid = dump_valid_q;
  assign dump_idx   = dump_idx_q;
  assign dump_done  = dump_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_perf_memsys_ctrl.sv
// Directed bench for perf_memsys_ctrl: vector table for counter/pending
// behaviour plus hand sequences for dump, underflow, async reset and wrap.
module tb_perf_memsys_ctrl;

  localparam int W     = 44;
  localparam int WW    = 4;
  localparam int PENDW = 7;

  logic clk = 1'b0;
  logic reset;
  logic mem_req_valid, mem_req_ready, mem_req_rw;
  logic mem_rsp_valid, mem_rsp_ready;
  logic ctrl_enable, ctrl_clear, dump_start, dump_ready;

  logic             dump_valid, dump_done, busy, err_underflow;
  logic [1:0]       dump_idx;
  logic [W-1:0]     dump_data, mem_reads, mem_writes, mem_latency;
  logic [PENDW-1:0] pending_reads;

  logic             w_dump_valid, w_dump_done, w_busy, w_err_underflow;
  logic [1:0]       w_dump_idx;
  logic [WW-1:0]    w_dump_data, w_mem_reads, w_mem_writes, w_mem_latency;
  logic [PENDW-1:0] w_pending_reads;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  perf_memsys_ctrl u_dut (
    .clk           (clk),
    .reset         (reset),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_rw    (mem_req_rw),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_ready (mem_rsp_ready),
    .ctrl_enable   (ctrl_enable),
    .ctrl_clear    (ctrl_clear),
    .dump_start    (dump_start),
    .dump_valid    (dump_valid),
    .dump_ready    (dump_ready),
    .dump_idx      (dump_idx),
    .dump_data     (dump_data),
    .dump_done     (dump_done),
    .busy          (busy),
    .pending_reads (pending_reads),
    .err_underflow (err_underflow),
    .mem_reads     (mem_reads),
    .mem_writes    (mem_writes),
    .mem_latency   (mem_latency)
  );

  // Narrow-counter instance so the wrap boundary is reachable in a few cycles.
  perf_memsys_ctrl #(.PERF_CTR_BITS(WW)) u_wrap (
    .clk           (clk),
    .reset         (reset),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_rw    (mem_req_rw),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_ready (mem_rsp_ready),
    .ctrl_enable   (ctrl_enable),
    .ctrl_clear    (ctrl_clear),
    .dump_start    (dump_start),
    .dump_valid    (w_dump_valid),
    .dump_ready    (dump_ready),
    .dump_idx      (w_dump_idx),
    .dump_data     (w_dump_data),
    .dump_done     (w_dump_done),
    .busy          (w_busy),
    .pending_reads (w_pending_reads),
    .err_underflow (w_err_underflow),
    .mem_reads     (w_mem_reads),
    .mem_writes    (w_mem_writes),
    .mem_latency   (w_mem_latency)
  );

  typedef struct {
    int     n;
    logic   rd, wr, rsp, en, clr, stall;
    int     pend;
    longint reads, writes, lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic rsp,
                       input logic en, input logic clr, input logic stall);
    mem_req_valid = rd | wr;
    mem_req_rw    = wr;
    mem_req_ready = ~stall;
    mem_rsp_valid = rsp;
    mem_rsp_ready = ~stall;
    ctrl_enable   = en;
    ctrl_clear    = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    dump_start = 1'b0;
    dump_ready = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    check("rst_pend",  pending_reads, 0);
    check("rst_reads", mem_reads,     0);
    check("rst_lat",   mem_latency,   0);
    check("rst_valid", dump_valid,    0);
    check("rst_busy",  busy,          0);
    check("rst_err",   err_underflow, 0);
    check("rst_idx",   dump_idx,      0);
    reset = 1'b0;

    //              n rd wr rs en cl st  pend reads wr  lat
    vecs.push_back('{1, 1, 0, 0, 1, 0, 0,  1,  1,  0,  0});
    vecs.push_back('{1, 1, 0, 0, 1, 0, 0,  2,  2,  0,  1});
    vecs.push_back('{1, 1, 0, 0, 1, 0, 0,  3,  3,  0,  3});
    vecs.push_back('{8, 0, 0, 0, 1, 0, 0,  3,  3,  0, 27});
    vecs.push_back('{1, 0, 0, 1, 1, 0, 0,  2,  3,  0, 30});
    vecs.push_back('{1, 0, 0, 1, 1, 0, 0,  1,  3,  0, 32});
    vecs.push_back('{1, 0, 0, 1, 1, 0, 0,  0,  3,  0, 33});
    vecs.push_back('{1, 0, 0, 0, 1, 0, 0,  0,  3,  0, 33});
    vecs.push_back('{1, 1, 0, 1, 1, 0, 1,  0,  3,  0, 33});
    vecs.push_back('{1, 1, 0, 0, 1, 0, 0,  1,  4,  0, 33});
    vecs.push_back('{1, 1, 0, 0, 1, 0, 0,  2,  5,  0, 34});
    vecs.push_back('{1, 1, 0, 1, 1, 0, 0,  2,  6,  0, 36});
    vecs.push_back('{1, 0, 0, 1, 1, 0, 0,  1,  6,  0, 38});
    vecs.push_back('{4, 0, 1, 0, 0, 0, 0,  1,  6,  0, 38});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0,  1,  6,  0, 38});
    vecs.push_back('{1, 1, 0, 0, 0, 0, 0,  2,  6,  0, 38});
    vecs.push_back('{1, 0, 1, 0, 1, 0, 0,  2,  6,  1, 40});
    vecs.push_back('{1, 0, 1, 0, 1, 0, 0,  2,  6,  2, 42});
    vecs.push_back('{1, 0, 1, 0, 1, 1, 0,  2,  0,  0,  0});
    vecs.push_back('{1, 0, 1, 0, 1, 0, 0,  2,  0,  1,  2});
    vecs.push_back('{1, 0, 0, 1, 1, 0, 0,  1,  0,  1,  4});
    vecs.push_back('{1, 0, 0, 1, 1, 0, 0,  0,  0,  1,  5});
    vecs.push_back('{1, 0, 0, 0, 1, 1, 0,  0,  0,  0,  0});
    vecs.push_back('{1, 1, 0, 0, 1, 0, 0,  1,  1,  0,  0});
    vecs.push_back('{5, 0, 1, 0, 1, 0, 0,  1,  1,  5,  5});
    vecs.push_back('{6, 1, 0, 0, 1, 0, 0,  7,  7,  5, 26});
    vecs.push_back('{2, 0, 0, 0, 1, 0, 0,  7,  7,  5, 40});

    foreach (vecs[i]) begin
      drive(vecs[i].rd, vecs[i].wr, vecs[i].rsp, vecs[i].en, vecs[i].clr, vecs[i].stall);
      repeat (vecs[i].n) tick();
      check($sformatf("v%0d_pend",   i), pending_reads, vecs[i].pend);
      check($sformatf("v%0d_reads",  i), mem_reads,     vecs[i].reads);
      check($sformatf("v%0d_writes", i), mem_writes,    vecs[i].writes);
      check($sformatf("v%0d_lat",    i), mem_latency,   vecs[i].lat);
      check($sformatf("v%0d_err",    i), err_underflow, 0);
    end

    // Dump of reads=7, writes=5, latency=40 with traffic continuing.
    drive(1, 0, 0, 1, 0, 0);
    dump_start = 1'b1;
    tick();
    check("d_busy",  busy,          1);
    check("d_valid", dump_valid,    1);
    check("d_idx0",  dump_idx,      0);
    check("d_data0", dump_data,     7);
    check("d_live_reads", mem_reads,   8);
    check("d_live_lat",   mem_latency, 47);
    drive(0, 0, 0, 1, 0, 0);
    dump_ready = 1'b1;
    tick();
    check("d_idx1",  dump_idx,  1);
    check("d_data1", dump_data, 5);
    dump_start = 1'b0;
    dump_ready = 1'b0;
    drive(0, 1, 0, 1, 1, 0);
    tick();
    check("d_clr_writes", mem_writes, 0);
    check("d_clr_reads",  mem_reads,  0);
    drive(0, 1, 0, 1, 0, 0);
    for (int s = 0; s < 2; s++) begin
      check($sformatf("d_stall%0d_idx", s),   dump_idx,   1);
      check($sformatf("d_stall%0d_data", s),  dump_data,  5);
      check($sformatf("d_stall%0d_valid", s), dump_valid, 1);
      check($sformatf("d_stall%0d_done", s),  dump_done,  0);
      tick();
    end
    check("d_stall2_data", dump_data, 5);
    dump_ready = 1'b1;
    tick();
    check("d_idx2",  dump_idx,   2);
    check("d_data2", dump_data,  40);
    check("d_done_early", dump_done, 0);
    tick();
    check("d_done",        dump_done,  1);
    check("d_valid_off",   dump_valid, 0);
    check("d_busy_done",   busy,       1);
    dump_ready = 1'b0;
    tick();
    check("d_done_pulse",  dump_done,  0);
    check("d_busy_idle",   busy,       0);
    tick();
    check("d_no_restart",  busy,       0);

    // Underflow, then asynchronous reset in the middle of a dump.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("u_pend0", pending_reads, 0);
    drive(0, 0, 1, 1, 0, 0);
    tick();
    check("u_err_set",  err_underflow, 1);
    check("u_pend_hold", pending_reads, 0);
    drive(0, 1, 0, 1, 1, 0);
    tick();
    check("u_err_clr_sticky", err_underflow, 1);
    drive(0, 1, 0, 1, 0, 0);
    repeat (2) tick();
    check("u_err_sticky", err_underflow, 1);
    check("u_writes",     mem_writes,    2);
    drive(0, 0, 0, 1, 0, 0);
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    check("u_dump_valid", dump_valid, 1);
    check("u_dump_data",  dump_data,  0);
    #3 reset = 1'b1;
    #1;
    check("ar_valid",  dump_valid,    0);
    check("ar_busy",   busy,          0);
    check("ar_err",    err_underflow, 0);
    check("ar_writes", mem_writes,    0);
    check("ar_idx",    dump_idx,      0);
    tick();
    reset = 1'b0;

    // Counter wrap on the 4-bit instance.
    drive(1, 0, 0, 1, 0, 0);
    repeat (15) tick();
    check("w_reads15", w_mem_reads, 15);
    tick();
    check("w_reads_wrap", w_mem_reads,   0);
    check("w_big_reads",  mem_reads,     16);
    check("w_pend",       pending_reads, 16);
    drive(0, 0, 0, 0, 0, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
